// File: rtl/crc_frame_serializer.sv
// crc_frame_serializer
// Feeds a serial CRC-8 generator: accepts parallel payload words over a
// valid/ready handshake, shifts each word out LSB-first with Active high,
// then waits for the generator's CRC burst (crc_valid high, then low)
// before taking the next frame. Completion, underrun and timeout are
// reported as registered single-cycle pulses.
module crc_frame_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic                  DATA,
    output logic                  Active,
    input  logic                  crc_valid,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  underrun,
    output logic                  timeout
);

    localparam int                 CNT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [7:0]         TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFT    = 2'd1,
        ST_WAIT_CRC = 2'd2
    } state_t;

    state_t                state_r, state_s;
    logic [DATA_WIDTH-1:0] shreg_r, shreg_s;
    logic                  last_r, last_s;
    logic [CNT_W-1:0]      bit_cnt_r, bit_cnt_s;
    logic [7:0]            tmo_cnt_r, tmo_cnt_s;
    logic                  seen_r, seen_s;
    logic                  data_r, data_s;
    logic                  active_r, active_s;
    logic                  frame_done_r, frame_done_s;
    logic                  underrun_r, underrun_s;
    logic                  timeout_r, timeout_s;
    logic                  ready_s;
    logic                  xfer_s;

    // Ready window decoded from registered state only: IDLE, or the last bit
    // of a word that is not flagged as the final word of the frame.
    always_comb begin
        ready_s = 1'b0;
        if (state_r == ST_IDLE) begin
            ready_s = 1'b1;
        end else if ((state_r == ST_SHIFT) && (bit_cnt_r == LAST_BIT) && !last_r) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
    end

    assign xfer_s     = in_valid & ready_s;
    assign in_ready   = ready_s;
    assign busy       = (state_r != ST_IDLE);
    assign DATA       = data_r;
    assign Active     = active_r;
    assign frame_done = frame_done_r;
    assign underrun   = underrun_r;
    assign timeout    = timeout_r;

    // Next-state and next-output logic; the serial bit registered for the
    // coming cycle is always the bit that will sit in shreg[0].
    always_comb begin
        state_s      = state_r;
        shreg_s      = shreg_r;
        last_s       = last_r;
        bit_cnt_s    = bit_cnt_r;
        tmo_cnt_s    = tmo_cnt_r;
        seen_s       = seen_r;
        data_s       = 1'b0;
        active_s     = 1'b0;
        frame_done_s = 1'b0;
        underrun_s   = 1'b0;
        timeout_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (xfer_s) begin
                    shreg_s   = in_data;
                    last_s    = in_last;
                    bit_cnt_s = {CNT_W{1'b0}};
                    data_s    = in_data[0];
                    active_s  = 1'b1;
                    state_s   = ST_SHIFT;
                end else begin
                    state_s   = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                if (bit_cnt_r != LAST_BIT) begin
                    shreg_s   = shreg_r >> 1;
                    bit_cnt_s = bit_cnt_r + CNT_W'(1);
                    data_s    = shreg_r[1];
                    active_s  = 1'b1;
                end else if (xfer_s) begin
                    // Seamless continuation: next word's bit 0 follows directly.
                    shreg_s   = in_data;
                    last_s    = in_last;
                    bit_cnt_s = {CNT_W{1'b0}};
                    data_s    = in_data[0];
                    active_s  = 1'b1;
                end else if (last_r) begin
                    tmo_cnt_s = 8'd0;
                    seen_s    = 1'b0;
                    state_s   = ST_WAIT_CRC;
                end else begin
                    // Upstream starved mid-frame: close the frame as a partial one.
                    underrun_s = 1'b1;
                    tmo_cnt_s  = 8'd0;
                    seen_s     = 1'b0;
                    state_s    = ST_WAIT_CRC;
                end
            end

            ST_WAIT_CRC: begin
                if (seen_r && !crc_valid) begin
                    frame_done_s = 1'b1;
                    state_s      = ST_IDLE;
                end else if (crc_valid) begin
                    // Once the burst has started it may last arbitrarily long.
                    seen_s = 1'b1;
                end else if (tmo_cnt_r == TMO_LAST) begin
                    timeout_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + 8'd1;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; asynchronous reset aborts any frame silently.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_r      <= ST_IDLE;
            shreg_r      <= {DATA_WIDTH{1'b0}};
            last_r       <= 1'b0;
            bit_cnt_r    <= {CNT_W{1'b0}};
            tmo_cnt_r    <= 8'd0;
            seen_r       <= 1'b0;
            data_r       <= 1'b0;
            active_r     <= 1'b0;
            frame_done_r <= 1'b0;
            underrun_r   <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            shreg_r      <= shreg_s;
            last_r       <= last_s;
            bit_cnt_r    <= bit_cnt_s;
            tmo_cnt_r    <= tmo_cnt_s;
            seen_r       <= seen_s;
            data_r       <= data_s;
            active_r     <= active_s;
            frame_done_r <= frame_done_s;
            underrun_r   <= underrun_s;
            timeout_r    <= timeout_s;
        end
    end

endmodule

// File: tb/tb_crc_frame_serializer.sv
// Directed testbench for crc_frame_serializer. Inputs change and outputs
// are sampled 1 time unit after each rising edge.
module tb_crc_frame_serializer;

    logic       clk = 1'b0;
    logic       RST;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       DATA;
    logic       Active;
    logic       crc_valid;
    logic       busy;
    logic       frame_done;
    logic       underrun;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    crc_frame_serializer #(.DATA_WIDTH(8), .TIMEOUT(16)) dut (
        .clk        (clk),
        .RST        (RST),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .DATA       (DATA),
        .Active     (Active),
        .crc_valid  (crc_valid),
        .busy       (busy),
        .frame_done (frame_done),
        .underrun   (underrun),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: CRC burst of n cycles, then crc_valid low for one edge.
    task automatic do_crc(input int n);
        crc_valid = 1'b1;
        repeat (n) tick();
        crc_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        RST = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; crc_valid = 1'b0;
        repeat (3) tick();
        checks++; if (DATA !== 1'b0)       begin failures++; $display("FAIL reset_data got=%b want=0", DATA); end
        checks++; if (Active !== 1'b0)     begin failures++; $display("FAIL reset_active got=%b want=0", Active); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (in_ready !== 1'b1)   begin failures++; $display("FAIL reset_ready got=%b want=1", in_ready); end
        checks++; if ({frame_done, underrun, timeout} !== 3'b000)
            begin failures++; $display("FAIL reset_pulses got=%b want=000", {frame_done, underrun, timeout}); end
        RST = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic exp_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}; // 0xA5
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_ready_idle got=%b want=1", in_ready); end
        in_data = 8'hA5; in_valid = 1'b1; in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (Active !== 1'b1) begin failures++; $display("FAIL single_active bit=%0d got=%b want=1", i, Active); end
            checks++; if (DATA !== exp_bits[i]) begin failures++; $display("FAIL single_data bit=%0d got=%b want=%b", i, DATA, exp_bits[i]); end
            tick();
        end
        checks++; if (Active !== 1'b0) begin failures++; $display("FAIL single_active_end got=%b want=0", Active); end
        checks++; if (busy !== 1'b1)   begin failures++; $display("FAIL single_busy_wait got=%b want=1", busy); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL single_ready_wait got=%b want=0", in_ready); end
        crc_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL single_early_done cyc=%0d got=%b want=0", i, frame_done); end
        end
        crc_valid = 1'b0;
        tick();
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL single_done got=%b want=1", frame_done); end
        checks++; if (in_ready !== 1'b1)   begin failures++; $display("FAIL single_ready_after got=%b want=1", in_ready); end
        tick();
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL single_done_width got=%b want=0", frame_done); end
    endtask

    task automatic test_back_to_back();
        logic exp_bits [16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        in_data = 8'h01; in_valid = 1'b1; in_last = 1'b0;
        tick();
        in_data = 8'h80; in_last = 1'b1;   // held valid; only taken at bit 7
        for (int i = 0; i < 16; i++) begin
            checks++; if (Active !== 1'b1) begin failures++; $display("FAIL b2b_active bit=%0d got=%b want=1", i, Active); end
            checks++; if (DATA !== exp_bits[i]) begin failures++; $display("FAIL b2b_data bit=%0d got=%b want=%b", i, DATA, exp_bits[i]); end
            checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL b2b_underrun bit=%0d got=%b want=0", i, underrun); end
            if (i == 3) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_mid got=%b want=0", in_ready); end
            end
            if (i == 7) begin
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_bit7 got=%b want=1", in_ready); end
            end
            if (i == 15) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_last got=%b want=0", in_ready); end
                crc_valid = 1'b1;   // already high when WAIT_CRC is entered
            end
            tick();
            if (i == 7) in_valid = 1'b0;
        end
        checks++; if (Active !== 1'b0)   begin failures++; $display("FAIL b2b_active_end got=%b want=0", Active); end
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL b2b_underrun_end got=%b want=0", underrun); end
        tick();
        crc_valid = 1'b0;
        tick();
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b want=1", frame_done); end
        tick();
    endtask

    task automatic test_underrun();
        logic exp_bits [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // 0x3C
        in_data = 8'h3C; in_valid = 1'b1; in_last = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (DATA !== exp_bits[i]) begin failures++; $display("FAIL urun_data bit=%0d got=%b want=%b", i, DATA, exp_bits[i]); end
            tick();
        end
        checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL urun_pulse got=%b want=1", underrun); end
        checks++; if (Active !== 1'b0)   begin failures++; $display("FAIL urun_active got=%b want=0", Active); end
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0)
            begin failures++; $display("FAIL urun_wait_state busy=%b ready=%b want busy=1 ready=0", busy, in_ready); end
        tick();
        checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL urun_width got=%b want=0", underrun); end
        // Long burst beyond TIMEOUT must not time out once seen.
        crc_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL urun_long_burst cyc=%0d got=%b want=0", i, timeout); end
        end
        crc_valid = 1'b0;
        tick();
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL urun_done got=%b want=1", frame_done); end
        tick();
    endtask

    task automatic test_timeout();
        in_data = 8'hFF; in_valid = 1'b1; in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();   // edge that enters WAIT_CRC
        checks++; if (Active !== 1'b0 || busy !== 1'b1)
            begin failures++; $display("FAIL tmo_entry active=%b busy=%b want active=0 busy=1", Active, busy); end
        for (int n = 1; n <= 16; n++) begin
            tick();
            if (n < 16) begin
                checks++; if (timeout !== 1'b0 || busy !== 1'b1)
                    begin failures++; $display("FAIL tmo_early n=%0d timeout=%b busy=%b want 0,1", n, timeout, busy); end
            end else begin
                checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL tmo_pulse got=%b want=1", timeout); end
                checks++; if (busy !== 1'b0 || frame_done !== 1'b0)
                    begin failures++; $display("FAIL tmo_idle busy=%b done=%b want 0,0", busy, frame_done); end
            end
        end
        tick();
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL tmo_width got=%b want=0", timeout); end
    endtask

    task automatic test_async_reset();
        logic exp_bits [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}; // 0x0F
        in_data = 8'h5A; in_valid = 1'b1; in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();   // bit 4 of 0x5A on DATA
        checks++; if (DATA !== 1'b1 || Active !== 1'b1)
            begin failures++; $display("FAIL arst_pre data=%b active=%b want 1,1", DATA, Active); end
        #2 RST = 1'b0;
        #1;
        checks++; if (DATA !== 1'b0 || Active !== 1'b0 || busy !== 1'b0)
            begin failures++; $display("FAIL arst_async data=%b active=%b busy=%b want 0,0,0", DATA, Active, busy); end
        checks++; if ({frame_done, underrun, timeout} !== 3'b000)
            begin failures++; $display("FAIL arst_pulses got=%b want=000", {frame_done, underrun, timeout}); end
        tick();
        RST = 1'b1;
        tick();
        in_data = 8'h0F; in_valid = 1'b1; in_last = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (DATA !== exp_bits[i] || Active !== 1'b1)
                begin failures++; $display("FAIL arst_frame bit=%0d data=%b active=%b want %b,1", i, DATA, Active, exp_bits[i]); end
            tick();
        end
        do_crc(3);
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL arst_done got=%b want=1", frame_done); end
        tick();
    endtask

    task automatic test_hold_valid();
        // 0x12 then 0x77 offered during bit 3, taken only at bit 7
        logic exp_bits [16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        in_data = 8'h12; in_valid = 1'b1; in_last = 1'b0;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin
                in_data = 8'h77; in_valid = 1'b1; in_last = 1'b1;
                #1;
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_ready_bit3 got=%b want=0", in_ready); end
            end
            if (i == 7) begin
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hold_ready_bit7 got=%b want=1", in_ready); end
            end
            checks++; if (DATA !== exp_bits[i] || Active !== 1'b1)
                begin failures++; $display("FAIL hold_data bit=%0d data=%b active=%b want %b,1", i, DATA, Active, exp_bits[i]); end
            tick();
            if (i == 7) in_valid = 1'b0;
        end
        checks++; if (Active !== 1'b0 || underrun !== 1'b0)
            begin failures++; $display("FAIL hold_end active=%b underrun=%b want 0,0", Active, underrun); end
        do_crc(2);
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL hold_done got=%b want=1", frame_done); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_underrun();
        test_timeout();
        test_async_reset();
        test_hold_valid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
